// File: rtl/ram_march_bist_if.sv
// Single-port SRAM bus between the march BIST engine (master) and the RAM (slave).
interface ram_march_bist_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output wr, output addr, output wdata, input rdata);
  modport slave  (input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/ram_march_bist.sv
// March C- style BIST engine for a single-port SRAM with configurable read latency.
// Walks M0 (write P up), M1 (read P / write ~P up), M2 (read ~P / write P down),
// M3 (read P up), counts mismatches and records the first failing location.
module ram_march_bist #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,   // legal range 1..4
  parameter int ERR_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   bg_pattern,
  ram_march_bist_if.master    ram,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_cnt,
  output logic [ADDR_W-1:0]   fail_addr,
  output logic [DATA_W-1:0]   fail_exp,
  output logic [DATA_W-1:0]   fail_got
);

  typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_M3, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  // Sub-cycle index of the compare cycle within one address slot
  localparam logic [2:0]        SUB_CMP  = 3'(RD_LAT);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          sub_q, sub_d;
  logic [DATA_W-1:0]   pat_q, pat_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [ADDR_W-1:0]   faddr_q, faddr_d;
  logic [DATA_W-1:0]   fexp_q, fexp_d;
  logic [DATA_W-1:0]   fgot_q, fgot_d;

  logic                cmp_en;
  logic                mism;
  logic                last_addr;
  logic [DATA_W-1:0]   exp_data;

  // Mismatch counter holds at all-ones instead of wrapping
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  // Only M2 reads back the inverted background
  assign exp_data  = (state_q == S_M2) ? ~pat_q : pat_q;
  assign cmp_en    = ((state_q == S_M1) || (state_q == S_M2) || (state_q == S_M3)) &&
                     (sub_q == SUB_CMP);
  assign mism      = cmp_en && (ram.rdata != exp_data);
  // M2 is the only descending element, so it terminates at address 0
  assign last_addr = (state_q == S_M2) ? (addr_q == '0) : (addr_q == ADDR_MAX);

  // Next-state, bus and result computation for the march sequencer
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sub_d   = sub_q;
    pat_d   = pat_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    faddr_d = faddr_q;
    fexp_d  = fexp_q;
    fgot_d  = fgot_q;

    // First mismatch is captured only while the counter is still zero
    if (mism) begin
      err_d = sat_inc(err_q);
      if (err_q == '0) begin
        faddr_d = addr_q;
        fexp_d  = exp_data;
        fgot_d  = ram.rdata;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d   = bg_pattern;
          err_d   = '0;
          pass_d  = 1'b0;
          faddr_d = '0;
          fexp_d  = '0;
          fgot_d  = '0;
          state_d = S_M0;
          addr_d  = '0;
          sub_d   = '0;
          wr_d    = 1'b1;
          wdata_d = bg_pattern;
          busy_d  = 1'b1;
        end
      end

      S_M0: begin
        if (addr_q == ADDR_MAX) begin
          state_d = S_M1;
          addr_d  = '0;
          sub_d   = '0;
          wr_d    = 1'b0;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          wr_d    = 1'b1;
        end
      end

      S_M1, S_M2, S_M3: begin
        if (sub_q != SUB_CMP) begin
          // Read or wait cycle: the address is held until the compare slot
          sub_d = sub_q + 3'd1;
          if ((sub_q + 3'd1) == SUB_CMP) begin
            wr_d = (state_q != S_M3);
            if (state_q == S_M1) begin
              wdata_d = ~pat_q;
            end else if (state_q == S_M2) begin
              wdata_d = pat_q;
            end
          end else begin
            wr_d = 1'b0;
          end
        end else begin
          // Compare cycle ends: step the address or hand over to the next element
          wr_d  = 1'b0;
          sub_d = '0;
          if (!last_addr) begin
            addr_d = (state_q == S_M2) ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
          end else if (state_q == S_M1) begin
            state_d = S_M2;
            addr_d  = ADDR_MAX;
          end else if (state_q == S_M2) begin
            state_d = S_M3;
            addr_d  = '0;
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        wr_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything so wr drops at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      sub_q   <= '0;
      pat_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      faddr_q <= '0;
      fexp_q  <= '0;
      fgot_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sub_q   <= sub_d;
      pat_q   <= pat_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      faddr_q <= faddr_d;
      fexp_q  <= fexp_d;
      fgot_q  <= fgot_d;
    end
  end

  assign ram.wr    = wr_q;
  assign ram.addr  = addr_q;
  assign ram.wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_addr = faddr_q;
  assign fail_exp  = fexp_q;
  assign fail_got  = fgot_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist: three engine instances (RD_LAT=1, RD_LAT=2,
// ERR_W=2) each with its own RAM model, selected one at a time by sel.
`timescale 1ns/1ps
module tb_ram_march_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] bg;
  int         sel;
  logic       flt;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  ram_march_bist_if #(.ADDR_W(4), .DATA_W(8)) b0 ();
  ram_march_bist_if #(.ADDR_W(4), .DATA_W(8)) b1 ();
  ram_march_bist_if #(.ADDR_W(4), .DATA_W(8)) b2 ();

  logic       start0, start1, start2;
  logic       busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
  logic [7:0] err0, err1;
  logic [1:0] err2;
  logic [3:0] fa0, fa1, fa2;
  logic [7:0] fe0, fe1, fe2, fg0, fg1, fg2;

  assign start0 = start && (sel == 0);
  assign start1 = start && (sel == 1);
  assign start2 = start && (sel == 2);

  ram_march_bist #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1), .ERR_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .bg_pattern(bg), .ram(b0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .fail_addr(fa0), .fail_exp(fe0), .fail_got(fg0));

  ram_march_bist #(.ADDR_W(4), .DATA_W(8), .RD_LAT(2), .ERR_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bg_pattern(bg), .ram(b1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_addr(fa1), .fail_exp(fe1), .fail_got(fg1));

  ram_march_bist #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bg_pattern(bg), .ram(b2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .fail_addr(fa2), .fail_exp(fe2), .fail_got(fg2));

  // RAM models
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  logic [7:0] mem2 [16];
  logic [7:0] rd0, rd1a, rd1b;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
      mem2[i] = 8'h00;
    end
  end

  // 1-cycle RAM; optional stuck-at-1 on bit0 when reading address 5
  always @(posedge clk) begin
    if (b0.wr) mem0[b0.addr] <= b0.wdata;
    rd0 <= (flt && b0.addr == 4'd5) ? (mem0[b0.addr] | 8'h01) : mem0[b0.addr];
  end
  assign b0.rdata = rd0;

  // 2-cycle RAM
  always @(posedge clk) begin
    if (b1.wr) mem1[b1.addr] <= b1.wdata;
    rd1a <= mem1[b1.addr];
    rd1b <= rd1a;
  end
  assign b1.rdata = rd1b;

  // RAM whose read path is broken: always returns zero
  always @(posedge clk) begin
    if (b2.wr) mem2[b2.addr] <= b2.wdata;
  end
  assign b2.rdata = 8'h00;

  // Selected-instance view
  logic       busy_m, done_m, pass_m, wr_m;
  logic [3:0] addr_m, fa_m;
  logic [7:0] wd_m, err_m, fe_m, fg_m;

  always_comb begin
    busy_m = busy0; done_m = done0; pass_m = pass0; wr_m = b0.wr;
    addr_m = b0.addr; wd_m = b0.wdata; err_m = err0;
    fa_m = fa0; fe_m = fe0; fg_m = fg0;
    if (sel == 1) begin
      busy_m = busy1; done_m = done1; pass_m = pass1; wr_m = b1.wr;
      addr_m = b1.addr; wd_m = b1.wdata; err_m = err1;
      fa_m = fa1; fe_m = fe1; fg_m = fg1;
    end else if (sel == 2) begin
      busy_m = busy2; done_m = done2; pass_m = pass2; wr_m = b2.wr;
      addr_m = b2.addr; wd_m = b2.wdata; err_m = {6'b0, err2};
      fa_m = fa2; fe_m = fe2; fg_m = fg2;
    end
  end

  logic       tr_wr   [160];
  logic [3:0] tr_addr [160];
  logic [7:0] tr_wd   [160];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse start on instance s and follow the run to its done pulse
  task automatic run(input int s, input logic [7:0] p, input bit repulse,
                     output int nb, output bit got_done);
    sel      = s;
    bg       = p;
    nb       = 0;
    got_done = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 400 && !got_done; c++) begin
      start = repulse && (c == 39);
      if (done_m) begin
        got_done = 1'b1;
      end else begin
        if (busy_m) begin
          if (nb < 160) begin
            tr_wr[nb]   = wr_m;
            tr_addr[nb] = addr_m;
            tr_wd[nb]   = wd_m;
          end
          nb++;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  // Count bus cycles that deviate from the expected march order
  function automatic int trace_bad(input int lat, input logic [7:0] p);
    int bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (tr_wr[k] !== 1'b1 || tr_addr[k] !== 4'(k) || tr_wd[k] !== p) bad++;
    end
    for (int e = 1; e <= 3; e++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j <= lat; j++) begin
          int         idx;
          logic       ew;
          logic [3:0] ea;
          idx = 16 + (e - 1) * 16 * (lat + 1) + i * (lat + 1) + j;
          ea  = (e == 2) ? 4'(15 - i) : 4'(i);
          ew  = (j == lat) && (e != 3);
          if (tr_wr[idx] !== ew || tr_addr[idx] !== ea) bad++;
          else if (ew && tr_wd[idx] !== ((e == 1) ? ~p : p)) bad++;
        end
      end
    end
    return bad;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    bit gd;
    int bad;
    rst   = 1'b1;
    start = 1'b0;
    bg    = 8'h00;
    sel   = 0;
    flt   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_wr",   b0.wr, 0);
    check("rst_err",  err0, 0);
    check("rst_fail", {fa0, fe0, fg0}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Fault-free run, P=0x55
    run(0, 8'h55, 1'b0, nb, gd);
    check("run55_done", gd, 1);
    check("run55_busy_cycles", nb, 112);
    check("run55_done_busy", busy_m, 0);
    check("run55_done_wr", wr_m, 0);
    check("run55_pass", pass_m, 1);
    check("run55_err", err_m, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem0[i] !== 8'h55) bad++;
    check("run55_mem", bad, 0);
    @(negedge clk);
    check("run55_done_pulse", done_m, 0);
    check("run55_pass_held", pass_m, 1);

    // Stuck bit0 at address 5, P=0x00
    flt = 1'b1;
    run(0, 8'h00, 1'b0, nb, gd);
    flt = 1'b0;
    check("flt_done", gd, 1);
    check("flt_err", err_m, 2);
    check("flt_pass", pass_m, 0);
    check("flt_addr", fa_m, 5);
    check("flt_exp", fe_m, 8'h00);
    check("flt_got", fg_m, 8'h01);
    @(negedge clk);

    // Address order with a start re-pulse at cycle 40, P=0xA5
    run(0, 8'hA5, 1'b1, nb, gd);
    check("ord_done", gd, 1);
    check("ord_busy_cycles", nb, 112);
    check("ord_pass", pass_m, 1);
    check("ord_trace", trace_bad(1, 8'hA5), 0);
    @(negedge clk);
    check("ord_idle_after", busy_m, 0);

    // Reset in the middle of M2 (err_cnt already 1 from the M1 fault)
    flt   = 1'b1;
    sel   = 0;
    bg    = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (61) @(negedge clk);
    check("mid_wr_pre", wr_m, 1);
    check("mid_addr_pre", addr_m, 9);
    check("mid_err_pre", err_m, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_wr_async", wr_m, 0);
    check("mid_busy_async", busy_m, 0);
    check("mid_err_async", err_m, 0);
    @(negedge clk);
    rst = 1'b0;
    flt = 1'b0;
    @(negedge clk);
    run(0, 8'h3C, 1'b0, nb, gd);
    check("rerun_done", gd, 1);
    check("rerun_busy_cycles", nb, 112);
    check("rerun_pass", pass_m, 1);
    @(negedge clk);

    // Two-cycle read latency, P=0xFF
    run(1, 8'hFF, 1'b0, nb, gd);
    check("lat2_done", gd, 1);
    check("lat2_busy_cycles", nb, 160);
    check("lat2_pass", pass_m, 1);
    check("lat2_err", err_m, 0);
    check("lat2_trace", trace_bad(2, 8'hFF), 0);
    @(negedge clk);

    // Saturating 2-bit counter against an all-zero read path, P=0xFF
    run(2, 8'hFF, 1'b0, nb, gd);
    check("sat_done", gd, 1);
    check("sat_busy_cycles", nb, 112);
    check("sat_err", err_m, 3);
    check("sat_pass", pass_m, 0);
    check("sat_addr", fa_m, 0);
    check("sat_exp", fe_m, 8'hFF);
    check("sat_got", fg_m, 8'h00);
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem2[i] !== 8'hFF) bad++;
    check("sat_mem", bad, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ram_march_bist.md
Name: ram_march_bist

Overview:
- Initiator-side engine that drives the single-port SRAM interface (clk, rst, wr, wdata, addr, rdata) and checks every location with a March C- style pattern.
- Sits in front of the RAM in place of the bench driver; a host pulses start, then reads back pass, error count and first-failure details.
- Provides self-checking of the RAM without the testbench scoreboard.

Parameters:
ADDR_W, 4, address width; DEPTH = 2**ADDR_W locations
DATA_W, 8, RAM data width
RD_LAT, 1, cycles from read address presented (wr=0) to rdata valid; legal range 1..4
ERR_W, 8, mismatch counter width

Ports:
clk  input  1  RAM/system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle request to run the test; sampled only in IDLE
bg_pattern  input  DATA_W  data background P; latched on accepted start
wr  output  1  RAM write enable (1 = write, 0 = read/idle)
addr  output  ADDR_W  RAM address
wdata  output  DATA_W  RAM write data
rdata  input  DATA_W  RAM read data, valid RD_LAT cycles after the read cycle
busy  output  1  high from the cycle after start is accepted until the last compare cycle, inclusive
done  output  1  one-cycle pulse after completion
pass  output  1  1 when the completed run had err_cnt==0; held until the next start
err_cnt  output  ERR_W  mismatch count, saturating
fail_addr  output  ADDR_W  address of the first mismatch
fail_exp  output  DATA_W  expected data at the first mismatch
fail_got  output  DATA_W  rdata at the first mismatch

Behaviour:
- Reset (async, any state): all outputs 0, FSM to IDLE. wr drops immediately without waiting for a clock edge. Latched pattern is cleared.
- FSM states: IDLE, M0, M1, M2, M3, DONE.
- IDLE: start=1 at edge T latches bg_pattern into P. At the same edge: clear err_cnt, pass and fail_* and move to M0. busy=1 from T onward.
- M0 (ascending 0..DEPTH-1): write P, one cycle per address (wr=1).
- M1 (ascending): for each address:
  - read cycle (wr=0);
  - RD_LAT-1 wait cycles (wr=0, addr held);
  - compare/write cycle: compare rdata with P, issue write of ~P (wr=1) to the same address.
  - RD_LAT+1 cycles per address.
- M2 (descending DEPTH-1..0): same as M1, but expects ~P and writes P.
- M3 (ascending): read cycle, RD_LAT-1 waits, then compare cycle expecting P with wr=0. RD_LAT+1 cycles per address.
- Addressing:
  - Each element ends on its terminal address (DEPTH-1 ascending, 0 descending).
  - The address counter never wraps inside an element.
  - The next element reloads its start address in the following cycle.
- When not writing, wdata holds its last value. Only wr qualifies writes.
- Mismatch in any compare cycle:
  - err_cnt increments, saturating at all-ones.
  - If this is the first mismatch (err_cnt was 0), capture fail_addr, fail_exp and fail_got. Later mismatches never overwrite them.
- After the last M3 compare cycle:
  - DONE for exactly one cycle: done=1, busy=0, wr=0, pass=(err_cnt==0).
  - Then IDLE.
- start is ignored while busy and during DONE.
- Run length from start edge T: DEPTH + 3*DEPTH*(RD_LAT+1) busy cycles. done is high in the following cycle.
- Reset mid-run: aborts cleanly. The RAM contents are left as-is. The next start runs a full test from M0.

Test Plan:
- Fault-free RAM, ADDR_W=4, DATA_W=8, RD_LAT=1, start with bg_pattern=0x55 → busy for exactly 112 cycles, done pulse in cycle 113, pass=1, err_cnt=0, final RAM contents all 0x55.
- RAM model forces rdata bit0=1 on reads of addr 5, bg_pattern=0x00 → mismatch in M1 at addr 5 and in M3 at addr 5 (M2 passes). Required: err_cnt=2, pass=0, fail_addr=5, fail_exp=0x00, fail_got=0x01.
- Address-order monitor, bg_pattern=0xA5:
  - M0: writes 0..15, wdata=0xA5.
  - M1: writes 0x5A ascending.
  - M2: reads/writes descending 15..0 with writes of 0xA5.
  - M3: 16 reads ascending with wr=0 throughout.
- start re-pulsed at cycle 40 → ignored, run completes at 112. Assert rst mid-M2 → wr, busy and err_cnt go 0 asynchronously. Release rst, start again → full 112-cycle run, pass=1.
- RD_LAT=2, RAM with 2-cycle read latency, bg_pattern=0xFF → 160 busy cycles, pass=1. Every compare occurs 2 cycles after its read cycle.
- ERR_W=2, RAM returns 0x00 for all reads, bg_pattern=0xFF:
  - M1 all fail, M2 passes, M3 all fail.
  - err_cnt saturates at 3, pass=0.
  - fail_addr=0, fail_exp=0xFF, fail_got=0x00.
